// File: rtl/ram_stream_fifo_ctrl.sv
// Stream FIFO controller for a single-clock true dual-port block RAM.
// Port A writes, port B reads, and a small skid FIFO absorbs reads already in flight.
package ram_stream_fifo_pkg;
    function automatic int clogb2(input int depth);
        int d;
        int r;
        d = depth;
        r = 0;
        while (d > 0) begin
            r = r + 1;
            d = d >> 1;
        end
        return r;
    endfunction
endpackage

module ram_stream_fifo_ctrl
    import ram_stream_fifo_pkg::*;
#(
    parameter int RAM_WIDTH  = 18,
    parameter int RAM_DEPTH  = 1024,
    parameter int RD_LATENCY = 2,
    localparam int ADDR_W    = clogb2(RAM_DEPTH - 1)
) (
    input  logic                 clka,
    input  logic                 rsta,
    input  logic [RAM_WIDTH-1:0] s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [RAM_WIDTH-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [ADDR_W:0]      count,
    output logic                 full,
    output logic                 empty,
    output logic [ADDR_W-1:0]    ram_addra,
    output logic [RAM_WIDTH-1:0] ram_dina,
    output logic                 ram_ena,
    output logic                 ram_wea,
    output logic [ADDR_W-1:0]    ram_addrb,
    output logic                 ram_enb,
    output logic                 ram_web,
    output logic                 ram_regceb,
    output logic                 ram_rstb,
    input  logic [RAM_WIDTH-1:0] ram_doutb
);

    localparam int SKID_D = RD_LATENCY + 1;
    localparam int SC_W   = clogb2(SKID_D);
    localparam int SI_W   = clogb2(SKID_D - 1);
    localparam int CW     = ADDR_W + 1;

    logic [ADDR_W-1:0]    wr_ptr_r;
    logic [ADDR_W-1:0]    rd_ptr_r;
    logic [CW-1:0]        ram_occ_r;
    logic [SC_W-1:0]      inflight_r;
    logic [SC_W-1:0]      skid_cnt_r;
    logic [RD_LATENCY-1:0] tag_r;
    logic [SI_W-1:0]      skid_wr_r;
    logic [SI_W-1:0]      skid_rd_r;
    logic [RAM_WIDTH-1:0] skid_mem_r [SKID_D];
    logic                 ready_en_r;

    logic                 m_valid_s;
    logic                 full_s;
    logic                 s_ready_s;
    logic                 wr_fire_s;
    logic                 pop_s;
    logic                 push_s;
    logic                 rd_issue_s;
    logic [SC_W:0]        credit_s;
    logic [CW-1:0]        count_s;

    // Handshakes, read-issue credit and occupancy flags.
    always_comb begin
        m_valid_s  = (skid_cnt_r != {SC_W{1'b0}});
        full_s     = ((ram_occ_r + CW'(inflight_r)) == CW'(RAM_DEPTH));
        s_ready_s  = ready_en_r && !full_s;
        wr_fire_s  = s_valid && s_ready_s;
        pop_s      = m_valid_s && m_ready;
        push_s     = tag_r[RD_LATENCY-1];
        // A word popped this cycle frees its skid slot in time for a new issue.
        credit_s   = {1'b0, inflight_r} + {1'b0, skid_cnt_r} - {{SC_W{1'b0}}, pop_s};
        rd_issue_s = (ram_occ_r != {CW{1'b0}}) && (credit_s < (SC_W + 1)'(SKID_D));
        count_s    = ram_occ_r + CW'(inflight_r) + CW'(skid_cnt_r);
    end

    assign s_ready    = s_ready_s;
    assign m_valid    = m_valid_s;
    assign m_data     = skid_mem_r[skid_rd_r];
    assign count      = count_s;
    assign full       = full_s;
    assign empty      = (count_s == {CW{1'b0}});
    assign ram_addra  = wr_ptr_r;
    assign ram_dina   = s_data;
    assign ram_ena    = wr_fire_s;
    assign ram_wea    = wr_fire_s;
    assign ram_addrb  = rd_ptr_r;
    assign ram_enb    = rd_issue_s;
    assign ram_web    = 1'b0;
    assign ram_regceb = 1'b1;
    assign ram_rstb   = rsta;

    // Pointers, occupancy counters and the read-return tag pipeline.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            wr_ptr_r   <= {ADDR_W{1'b0}};
            rd_ptr_r   <= {ADDR_W{1'b0}};
            ram_occ_r  <= {CW{1'b0}};
            inflight_r <= {SC_W{1'b0}};
            skid_cnt_r <= {SC_W{1'b0}};
            tag_r      <= {RD_LATENCY{1'b0}};
            skid_wr_r  <= {SI_W{1'b0}};
            skid_rd_r  <= {SI_W{1'b0}};
            ready_en_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
            if (wr_fire_s) begin
                wr_ptr_r <= (wr_ptr_r == ADDR_W'(RAM_DEPTH - 1)) ? {ADDR_W{1'b0}} : wr_ptr_r + ADDR_W'(1);
            end
            if (rd_issue_s) begin
                rd_ptr_r <= (rd_ptr_r == ADDR_W'(RAM_DEPTH - 1)) ? {ADDR_W{1'b0}} : rd_ptr_r + ADDR_W'(1);
            end
            ram_occ_r  <= ram_occ_r + CW'(wr_fire_s) - CW'(rd_issue_s);
            inflight_r <= inflight_r + SC_W'(rd_issue_s) - SC_W'(push_s);
            skid_cnt_r <= skid_cnt_r + SC_W'(push_s) - SC_W'(pop_s);
            tag_r[0]   <= rd_issue_s;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_r[i] <= tag_r[i-1];
            end
            if (push_s) begin
                skid_wr_r <= (skid_wr_r == SI_W'(SKID_D - 1)) ? {SI_W{1'b0}} : skid_wr_r + SI_W'(1);
            end
            if (pop_s) begin
                skid_rd_r <= (skid_rd_r == SI_W'(SKID_D - 1)) ? {SI_W{1'b0}} : skid_rd_r + SI_W'(1);
            end
        end
    end

    // Skid storage; contents are meaningless until counted in skid_cnt_r.
    always_ff @(posedge clka) begin
        if (push_s) begin
            skid_mem_r[skid_wr_r] <= ram_doutb;
        end
    end

endmodule
